// File: rtl/systolic_skew_if.sv
// Bus between the systolic controller/global buffer side and one skew stage.
// The master drives enable, bubble, flush and the read word; the slave returns the skewed edge.
interface systolic_skew_if #(
   parameter int LANES  = 10,
   parameter int DATA_W = 8
);
   logic                    ensys_i;
   logic                    bubble_i;
   logic                    clr_i;
   logic [LANES*DATA_W-1:0] data_i;
   logic [LANES*DATA_W-1:0] data_o;
   logic [LANES-1:0]        valid_o;
   logic                    busy_o;

   modport master (
      output ensys_i, bubble_i, clr_i, data_i,
      input  data_o, valid_o, busy_o
   );

   modport slave (
      input  ensys_i, bubble_i, clr_i, data_i,
      output data_o, valid_o, busy_o
   );
endinterface

// File: rtl/systolic_skew.sv
// Systolic input skew: lane j delays its element j+1 cycles so a parallel buffer word
// enters the PE array edge as a diagonal wavefront. Pure data movement, no stall.
module systolic_skew #(
   parameter int LANES  = 10,
   parameter int DATA_W = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   systolic_skew_if.slave bus
);
   logic                    load_vld;
   logic [LANES-1:0]        lane_busy;
   logic [LANES-1:0]        valid_out;
   logic [LANES*DATA_W-1:0] data_out;
   logic                    busy_d;
   logic                    busy_q;

   // Bubbles and idle cycles both enter as {0,0}, so bubble slots keep their diagonal place.
   assign load_vld = bus.ensys_i & ~bus.bubble_i;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      localparam int DEPTH = j + 1;

      logic [DATA_W-1:0]             load_dat;
      logic [DEPTH-1:0]              vld_sh;
      logic [DEPTH-1:0][DATA_W-1:0]  dat_sh;
      logic [DEPTH-1:0]              vld_d;
      logic [DEPTH-1:0]              vld_q;
      logic [DEPTH-1:0][DATA_W-1:0]  dat_d;
      logic [DEPTH-1:0][DATA_W-1:0]  dat_q;

      assign load_dat = load_vld ? bus.data_i[j*DATA_W +: DATA_W] : '0;

      if (DEPTH == 1) begin : g_one
         assign vld_sh = load_vld;
         assign dat_sh = load_dat;
      end else begin : g_many
         assign vld_sh = {vld_q[DEPTH-2:0], load_vld};
         assign dat_sh = {dat_q[DEPTH-2:0], load_dat};
      end

      always_comb begin
         vld_d = '0;
         dat_d = '0;
         if (!bus.clr_i) begin
            vld_d = vld_sh;
            dat_d = dat_sh;
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld_q <= '0;
            dat_q <= '0;
         end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
         end
      end

      // Masking is redundant with the {0,0} loads but keeps the PE edge clean by construction.
      assign valid_out[j]                  = vld_q[DEPTH-1];
      assign data_out[j*DATA_W +: DATA_W]  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;
      assign lane_busy[j]                  = |vld_q;
   end

   // Busy covers the incoming load plus everything already in flight; a flush clears it at once.
   always_comb begin
      busy_d = ~bus.clr_i & (load_vld | (|lane_busy));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign bus.data_o  = data_out;
   assign bus.valid_o = valid_out;
   assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_systolic_skew.sv
// Directed bench for systolic_skew: reset, single word, stream, bubbles, flush, back-to-back.
module tb_systolic_skew;
   localparam int LANES  = 10;
   localparam int DATA_W = 8;
   localparam int W      = LANES * DATA_W;
   localparam int MAXC   = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_skew_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

   systolic_skew #(.LANES(LANES), .DATA_W(DATA_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic             st_en  [MAXC];
   logic             st_bub [MAXC];
   logic             st_clr [MAXC];
   logic [W-1:0]     st_dat [MAXC];
   logic [LANES-1:0] cap_v  [MAXC+1];
   logic [W-1:0]     cap_d  [MAXC+1];
   logic             cap_b  [MAXC+1];

   function automatic logic [W-1:0] word_all(input logic [7:0] b);
      logic [W-1:0] w;
      for (int j = 0; j < LANES; j++) w[j*DATA_W +: DATA_W] = b;
      return w;
   endfunction

   task automatic clear_stim();
      for (int c = 0; c < MAXC; c++) begin
         st_en[c]  = 1'b0;
         st_bub[c] = 1'b0;
         st_clr[c] = 1'b0;
         st_dat[c] = word_all(8'hA5);
      end
   endtask

   // Lane j at output cycle c shows the word presented at cycle c-j-1, unless a flush hit it.
   function automatic void exp_at(input int n, input int c, input int j,
                                  output logic v, output logic [7:0] d);
      int idx;
      idx = c - j - 1;
      v = 1'b0;
      d = 8'h00;
      if (idx >= 0 && idx < n) begin
         if (st_en[idx] && !st_bub[idx]) begin
            v = 1'b1;
            for (int k = idx; k < c && k < n; k++) if (st_clr[k]) v = 1'b0;
            if (v) d = st_dat[idx][j*DATA_W +: DATA_W];
         end
      end
   endfunction

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         bus.ensys_i  = st_en[c];
         bus.bubble_i = st_bub[c];
         bus.clr_i    = st_clr[c];
         bus.data_i   = st_dat[c];
         @(posedge clk);
         #1;
         cap_v[c+1] = bus.valid_o;
         cap_d[c+1] = bus.data_o;
         cap_b[c+1] = bus.busy_o;
      end
      bus.ensys_i  = 1'b0;
      bus.bubble_i = 1'b0;
      bus.clr_i    = 1'b0;
      bus.data_i   = '0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (bus.valid_o !== '0 || bus.data_o !== '0 || bus.busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got v=%h d=%h busy=%b, want all 0", bus.valid_o, bus.data_o, bus.busy_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.ensys_i = 1'b1;
      bus.data_i  = word_all(8'h77);
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (bus.valid_o !== 10'b00_0000_0111 || bus.busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_prestream: got v=%b busy=%b, want v=0000000111 busy=1", bus.valid_o, bus.busy_o);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.valid_o !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_valid: got %b, want 0", bus.valid_o);
      end
      n_cmp++;
      if (bus.data_o !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_data: got %h, want 0", bus.data_o);
      end
      n_cmp++;
      if (bus.busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_busy: got %b, want 0", bus.busy_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.ensys_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.valid_o !== '0 || bus.data_o !== '0 || bus.busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_after%0d: got v=%h d=%h busy=%b, want all 0", i, bus.valid_o, bus.data_o, bus.busy_o);
         end
      end
   endtask

   task automatic test_single_word();
      logic       ev;
      logic [7:0] ed;
      int         n;
      n = 14;
      clear_stim();
      st_en[0] = 1'b1;
      for (int j = 0; j < LANES; j++) st_dat[0][j*DATA_W +: DATA_W] = 8'(j + 1);
      run(n);
      for (int c = 1; c <= n; c++) begin
         for (int j = 0; j < LANES; j++) begin
            exp_at(n, c, j, ev, ed);
            n_cmp++;
            if (cap_v[c][j] !== ev || cap_d[c][j*DATA_W +: DATA_W] !== ed) begin
               n_bad++;
               $display("FAIL single lane%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                        j, c, cap_v[c][j], cap_d[c][j*DATA_W +: DATA_W], ev, ed);
            end
         end
      end
      n_cmp++;
      if (cap_v[10][9] !== 1'b1 || cap_d[10][9*DATA_W +: DATA_W] !== 8'd10) begin
         n_bad++;
         $display("FAIL single_lane9_c10: got v=%b d=%h, want v=1 d=0a", cap_v[10][9], cap_d[10][9*DATA_W +: DATA_W]);
      end
      n_cmp++;
      if (cap_b[1] !== 1'b1 || cap_b[11] !== 1'b1 || cap_b[12] !== 1'b0) begin
         n_bad++;
         $display("FAIL single_busy: got c1=%b c11=%b c12=%b, want 1 1 0", cap_b[1], cap_b[11], cap_b[12]);
      end
   endtask

   task automatic test_stream();
      logic       ev;
      logic [7:0] ed;
      int         n;
      n = 16;
      clear_stim();
      for (int c = 0; c < 4; c++) begin
         st_en[c]  = 1'b1;
         st_dat[c] = word_all(8'(8'h10 + c));
      end
      run(n);
      for (int c = 1; c <= n; c++) begin
         for (int j = 0; j < LANES; j++) begin
            exp_at(n, c, j, ev, ed);
            n_cmp++;
            if (cap_v[c][j] !== ev || cap_d[c][j*DATA_W +: DATA_W] !== ed) begin
               n_bad++;
               $display("FAIL stream lane%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                        j, c, cap_v[c][j], cap_d[c][j*DATA_W +: DATA_W], ev, ed);
            end
         end
      end
      n_cmp++;
      if (cap_d[10][9*DATA_W +: DATA_W] !== 8'h10 || cap_d[13][9*DATA_W +: DATA_W] !== 8'h13
          || cap_v[14][9] !== 1'b0 || cap_v[9][9] !== 1'b0) begin
         n_bad++;
         $display("FAIL stream_lane9_window: got c10=%h c13=%h v9=%b v14=%b, want 10 13 0 0",
                  cap_d[10][9*DATA_W +: DATA_W], cap_d[13][9*DATA_W +: DATA_W], cap_v[9][9], cap_v[14][9]);
      end
   endtask

   task automatic test_bubble();
      logic       ev;
      logic [7:0] ed;
      int         n;
      n = 26;
      clear_stim();
      for (int c = 0; c < 4; c++) begin
         st_en[c]  = 1'b1;
         st_dat[c] = word_all(8'(8'h30 + c));
      end
      for (int c = 4; c < 10; c++) begin
         st_en[c]  = 1'b1;
         st_bub[c] = 1'b1;
         st_dat[c] = word_all(8'hEE);
      end
      for (int c = 10; c < 14; c++) begin
         st_en[c]  = 1'b1;
         st_dat[c] = word_all(8'(8'h20 + c - 10));
      end
      run(n);
      for (int c = 1; c <= n; c++) begin
         for (int j = 0; j < LANES; j++) begin
            exp_at(n, c, j, ev, ed);
            n_cmp++;
            if (cap_v[c][j] !== ev || cap_d[c][j*DATA_W +: DATA_W] !== ed) begin
               n_bad++;
               $display("FAIL bubble lane%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                        j, c, cap_v[c][j], cap_d[c][j*DATA_W +: DATA_W], ev, ed);
            end
         end
      end
      n_cmp++;
      if (cap_v[11][0] !== 1'b1 || cap_d[11][7:0] !== 8'h20) begin
         n_bad++;
         $display("FAIL bubble_next_batch_lane0: got v=%b d=%h, want v=1 d=20", cap_v[11][0], cap_d[11][7:0]);
      end
      n_cmp++;
      if (cap_v[8][3] !== 1'b0 || cap_d[8][3*DATA_W +: DATA_W] !== 8'h00) begin
         n_bad++;
         $display("FAIL bubble_slot_lane3: got v=%b d=%h, want v=0 d=00", cap_v[8][3], cap_d[8][3*DATA_W +: DATA_W]);
      end
   endtask

   task automatic test_clear();
      logic       ev;
      logic [7:0] ed;
      int         n;
      n = 18;
      clear_stim();
      for (int c = 0; c < 5; c++) begin
         st_en[c]  = 1'b1;
         st_dat[c] = word_all(8'(8'h40 + c));
      end
      st_clr[4] = 1'b1;
      st_en[5]  = 1'b1;
      st_dat[5] = word_all(8'h55);
      run(n);
      for (int c = 1; c <= n; c++) begin
         for (int j = 0; j < LANES; j++) begin
            exp_at(n, c, j, ev, ed);
            n_cmp++;
            if (cap_v[c][j] !== ev || cap_d[c][j*DATA_W +: DATA_W] !== ed) begin
               n_bad++;
               $display("FAIL clear lane%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                        j, c, cap_v[c][j], cap_d[c][j*DATA_W +: DATA_W], ev, ed);
            end
         end
      end
      n_cmp++;
      if (cap_v[5] !== '0 || cap_b[5] !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_flush: got v=%b busy=%b, want v=0 busy=0", cap_v[5], cap_b[5]);
      end
      n_cmp++;
      if (cap_v[6][0] !== 1'b1 || cap_d[6][7:0] !== 8'h55 || cap_b[6] !== 1'b1) begin
         n_bad++;
         $display("FAIL clear_resume: got v=%b d=%h busy=%b, want v=1 d=55 busy=1", cap_v[6][0], cap_d[6][7:0], cap_b[6]);
      end
   endtask

   task automatic test_back_to_back();
      logic       ev;
      logic [7:0] ed;
      int         n;
      int         run_len;
      n = 32;
      clear_stim();
      for (int c = 0; c < 20; c++) begin
         st_en[c]  = 1'b1;
         st_dat[c] = word_all(8'((((c / 10) + 1) << 4) | (c % 10)));
      end
      run(n);
      for (int c = 1; c <= n; c++) begin
         for (int j = 0; j < LANES; j++) begin
            exp_at(n, c, j, ev, ed);
            n_cmp++;
            if (cap_v[c][j] !== ev || cap_d[c][j*DATA_W +: DATA_W] !== ed) begin
               n_bad++;
               $display("FAIL b2b lane%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                        j, c, cap_v[c][j], cap_d[c][j*DATA_W +: DATA_W], ev, ed);
            end
         end
      end
      n_cmp++;
      if (cap_d[19][9*DATA_W +: DATA_W] !== 8'h19 || cap_d[20][9*DATA_W +: DATA_W] !== 8'h20) begin
         n_bad++;
         $display("FAIL b2b_lane9_seam: got c19=%h c20=%h, want 19 20",
                  cap_d[19][9*DATA_W +: DATA_W], cap_d[20][9*DATA_W +: DATA_W]);
      end
      run_len = 0;
      for (int c = 1; c <= n; c++) if (cap_v[c][5]) run_len++;
      n_cmp++;
      if (run_len != 20 || cap_v[6][5] !== 1'b1 || cap_v[25][5] !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_lane5_count: got %0d valid (c6=%b c25=%b), want 20 contiguous",
                  run_len, cap_v[6][5], cap_v[25][5]);
      end
   endtask

   initial begin
      bus.ensys_i  = 1'b0;
      bus.bubble_i = 1'b0;
      bus.clr_i    = 1'b0;
      bus.data_i   = '0;
      #1;
      test_reset();
      test_single_word();
      test_stream();
      test_bubble();
      test_clear();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
